// File: rtl/spi_slave_responder_if.sv
// Signal bundle between an SPI responder and its surroundings: the serial pins plus the
// host-side tx buffer handshake, rx word output and status pulses.
interface spi_slave_responder_if #(
  parameter int unsigned n = 8
) ();

  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic [n-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [n-1:0] rx_data;
  logic         rx_valid;
  logic         tx_underrun;
  logic         frame_err;
  logic         busy;

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    input  tx_data,
    input  tx_valid,
    output miso,
    output miso_oe,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output tx_underrun,
    output frame_err,
    output busy
  );

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    output tx_data,
    output tx_valid,
    input  miso,
    input  miso_oe,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  tx_underrun,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversamples the SPI pins in the clk domain, deserialises MOSI and
// serialises a one-deep buffered tx word onto MISO, with underrun and aborted-frame flags.
module spi_slave_responder #(
  parameter int unsigned n         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_slave_responder_if.slave   bus_io
);

  localparam int unsigned CntW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(n - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Sync chains: [0] and [1] are the synchroniser, [2] is the history flop.
  logic [2:0] sclk_sync_q, cs_sync_q, mosi_sync_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [n-1:0]    tx_shift_q, tx_shift_d;
  logic [n-1:0]    rx_shift_q, rx_shift_d;
  logic [n-1:0]    rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            tx_underrun_q, tx_underrun_d;
  logic            frame_err_q, frame_err_d;
  logic [n-1:0]    buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic accept, reload;
  logic [n-1:0] rx_next, tx_shifted;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  assign accept = bus_io.tx_valid & ~buf_valid_q;

  always_comb begin
    if (MSB_FIRST) begin
      rx_next    = {rx_shift_q[n-2:0], mosi_s};
      tx_shifted = {tx_shift_q[n-2:0], 1'b0};
    end else begin
      rx_next    = {mosi_s, rx_shift_q[n-1:1]};
      tx_shifted = {1'b0, tx_shift_q[n-1:1]};
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;
    buf_d         = buf_q;
    buf_valid_d   = buf_valid_q;
    reload        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StActive;
          bit_cnt_d = '0;
          reload    = 1'b1;
        end
      end
      StActive: begin
        // A cs_n edge takes priority; a coincident sclk edge is dropped.
        if (cs_rise) begin
          state_d     = StIdle;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          tx_shift_d  = '0;
          rx_shift_d  = '0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            reload = 1'b1;
          end else begin
            tx_shift_d = tx_shifted;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Reload sees the buffer as it was before this cycle's accept.
    if (reload) begin
      tx_shift_d    = buf_valid_q ? buf_q : '0;
      tx_underrun_d = ~buf_valid_q;
      buf_valid_d   = 1'b0;
    end
    if (accept) begin
      buf_d       = bus_io.tx_data;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // cs_n chain resets low so a frame cut by reset cannot restart without a fresh fall.
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      buf_q         <= '0;
      buf_valid_q   <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[1:0], bus_io.sclk};
      cs_sync_q     <= {cs_sync_q[1:0], bus_io.cs_n};
      mosi_sync_q   <= {mosi_sync_q[1:0], bus_io.mosi};
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
      buf_q         <= buf_d;
      buf_valid_q   <= buf_valid_d;
    end
  end

  logic active;
  assign active = (state_q == StActive);

  always_comb begin
    bus_io.miso = 1'b0;
    if (active) begin
      bus_io.miso = MSB_FIRST ? tx_shift_q[n-1] : tx_shift_q[0];
    end
  end

  assign bus_io.miso_oe     = active;
  assign bus_io.busy        = active;
  assign bus_io.tx_ready    = ~buf_valid_q;
  assign bus_io.rx_data     = rx_data_q;
  assign bus_io.rx_valid    = rx_valid_q;
  assign bus_io.tx_underrun = tx_underrun_q;
  assign bus_io.frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: drives mode-0 frames as an SPI master and checks
// the received word, MISO stream and status pulses against hand-computed values.
module tb_spi_slave_responder;

  localparam int H = 6;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_responder_if #(.n(8)) bus ();

  spi_slave_responder #(.n(8), .MSB_FIRST(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int errors = 0;
  int checks = 0;

  int rxv_cnt = 0;
  int un_cnt  = 0;
  int fe_cnt  = 0;
  logic [7:0] rx_log [0:15];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rxv_cnt[3:0]] <= bus.rx_data;
      rxv_cnt <= rxv_cnt + 1;
    end
    if (bus.tx_underrun) un_cnt <= un_cnt + 1;
    if (bus.frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    bus.sclk = 1'b0;
    bus.mosi = b;
    wait_clk(H);
    m = bus.miso;
    bus.sclk = 1'b1;
    wait_clk(H);
  endtask

  task automatic xfer(input logic [7:0] mo, output logic [7:0] mi);
    logic bit_in;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(mo[i], bit_in);
      mi[i] = bit_in;
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic end_frame();
    bus.sclk = 1'b0;
    wait_clk(H);
    bus.cs_n = 1'b1;
    wait_clk(H);
  endtask

  logic [7:0] mi0, mi1;
  logic       dummy;
  int         rx_base, un_base, fe_base;

  initial begin
    bus.sclk     = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(H);

    check("reset_miso", 32'(bus.miso), 32'h0);
    check("reset_miso_oe", 32'(bus.miso_oe), 32'h0);
    check("reset_tx_ready", 32'(bus.tx_ready), 32'h1);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_pulses", {29'd0, bus.rx_valid, bus.tx_underrun, bus.frame_err}, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);

    // 1: single word, preloaded tx
    push_tx(8'hDB);
    check("t1_tx_ready_full", 32'(bus.tx_ready), 32'h0);
    rx_base = rxv_cnt;
    un_base = un_cnt;
    bus.cs_n = 1'b0;
    wait_clk(H);
    check("t1_busy", 32'(bus.busy), 32'h1);
    check("t1_miso_oe", 32'(bus.miso_oe), 32'h1);
    check("t1_tx_ready_consumed", 32'(bus.tx_ready), 32'h1);
    xfer(8'h3D, mi0);
    check("t1_miso_stream", 32'(mi0), 32'hDB);
    check("t1_rx_data", 32'(bus.rx_data), 32'h3D);
    check("t1_rx_valid_count", 32'(rxv_cnt - rx_base), 32'd1);
    check("t1_no_underrun", 32'(un_cnt - un_base), 32'd0);
    bus.sclk = 1'b0;
    wait_clk(H);
    check("t1_trailing_underrun", 32'(un_cnt - un_base), 32'd1);
    bus.cs_n = 1'b1;
    wait_clk(H);
    check("t1_busy_off", 32'(bus.busy), 32'h0);
    check("t1_miso_idle", 32'(bus.miso), 32'h0);

    // 2: two words in one frame with refill
    push_tx(8'h4A);
    rx_base = rxv_cnt;
    un_base = un_cnt;
    bus.cs_n = 1'b0;
    wait_clk(H);
    check("t2_tx_ready", 32'(bus.tx_ready), 32'h1);
    push_tx(8'h1A);
    xfer(8'hA5, mi0);
    xfer(8'h5A, mi1);
    check("t2_miso_w0", 32'(mi0), 32'h4A);
    check("t2_miso_w1", 32'(mi1), 32'h1A);
    check("t2_rx_valid_count", 32'(rxv_cnt - rx_base), 32'd2);
    check("t2_rx_w0", 32'(rx_log[rx_base[3:0]]), 32'hA5);
    check("t2_rx_w1", 32'(rx_log[4'(rx_base + 1)]), 32'h5A);
    check("t2_no_underrun", 32'(un_cnt - un_base), 32'd0);
    end_frame();

    // 3: no preload
    rx_base = rxv_cnt;
    un_base = un_cnt;
    bus.cs_n = 1'b0;
    wait_clk(H);
    check("t3_start_underrun", 32'(un_cnt - un_base), 32'd1);
    xfer(8'hFF, mi0);
    check("t3_miso_zero", 32'(mi0), 32'h00);
    check("t3_rx_data", 32'(bus.rx_data), 32'hFF);
    end_frame();

    // 4: aborted frame after 5 bits
    rx_base = rxv_cnt;
    fe_base = fe_cnt;
    bus.cs_n = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(i[0], dummy);
    end_frame();
    check("t4_frame_err", 32'(fe_cnt - fe_base), 32'd1);
    check("t4_no_rx_valid", 32'(rxv_cnt - rx_base), 32'd0);
    check("t4_rx_data_kept", 32'(bus.rx_data), 32'hFF);
    check("t4_busy_off", 32'(bus.busy), 32'h0);

    // 5: reset mid-frame, then a clean frame
    bus.cs_n = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, dummy);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(H);
    check("t5_busy_after_rst", 32'(bus.busy), 32'h0);
    check("t5_rx_data_rst", 32'(bus.rx_data), 32'h0);
    check("t5_tx_ready_rst", 32'(bus.tx_ready), 32'h1);
    check("t5_miso_rst", {30'd0, bus.miso, bus.miso_oe}, 32'h0);
    end_frame();
    push_tx(8'hDB);
    rx_base = rxv_cnt;
    bus.cs_n = 1'b0;
    wait_clk(H);
    xfer(8'h3D, mi0);
    check("t5_rx_data", 32'(bus.rx_data), 32'h3D);
    check("t5_miso_stream", 32'(mi0), 32'hDB);
    check("t5_rx_valid_count", 32'(rxv_cnt - rx_base), 32'd1);
    end_frame();

    // 6: tx_valid held while buffer full
    bus.tx_data  = 8'hC3;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_data = 8'h11;
    wait_clk(1);
    bus.tx_data = 8'h22;
    wait_clk(1);
    check("t6_tx_ready_full", 32'(bus.tx_ready), 32'h0);
    bus.tx_valid = 1'b0;
    bus.cs_n = 1'b0;
    wait_clk(H);
    xfer(8'h00, mi0);
    check("t6_miso_first_word", 32'(mi0), 32'hC3);
    check("t6_rx_data", 32'(bus.rx_data), 32'h00);
    end_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
